// File: rtl/bl_pkg.sv
// Shared definitions for the backlight PWM block.
// Holds the PWM resolution constants, the controller state encoding and
// small unsigned min/max helpers used to form the target and entry duty.
package bl_pkg;

  localparam int PWM_W   = 12;
  localparam int PWM_MAX = 4095;

  // Last counter value of a period; the period is PWM_MAX ticks long so
  // that a duty of PWM_MAX means always high.
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_MAX - 1);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    RAMP = 2'b01,
    RUN  = 2'b10
  } bl_state_e;

  function automatic logic [PWM_W-1:0] umax(input logic [PWM_W-1:0] a,
                                            input logic [PWM_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [PWM_W-1:0] umin(input logic [PWM_W-1:0] a,
                                            input logic [PWM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler for the backlight PWM.
// Counts 0..PRESCALE-1 and asserts o_tick on the last count, so PRESCALE = 1
// ticks every cycle.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset
//   i_clear - synchronous clear, holds the count at 0 while the PWM is off
//   o_tick  - one-cycle tick that advances the PWM counter
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // Free-running modulo-PRESCALE count, restarted whenever the PWM is off
  // so the first period after enable has full-length ticks.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/backlight_pwm.sv
// Single-channel MiniLED backlight PWM generator.
// Turns the smoothed 12-bit brightness word into a glitch-free PWM drive.
// Duty only changes at period boundaries, a soft-start ramp runs after
// enable and a minimum-duty floor is applied to the target.
// Ports:
//   I_clk          - system clock
//   I_reset        - synchronous active-high reset
//   I_enable       - backlight enable, level-sensitive
//   I_bright_data  - requested brightness, sampled every cycle
//   O_pwm          - registered PWM drive
//   O_period_start - one-cycle pulse in the cycle the period counter reads 0
//   O_duty         - duty currently applied
//   O_ramping      - high while the soft-start ramp is running
module backlight_pwm
  import bl_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RAMP_STEP = 64,
  parameter int unsigned MIN_DUTY  = 32
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_enable,
  input  logic [PWM_W-1:0] I_bright_data,
  output logic             O_pwm,
  output logic             O_period_start,
  output logic [PWM_W-1:0] O_duty,
  output logic             O_ramping
);

  localparam logic [PWM_W-1:0] STEP  = PWM_W'(RAMP_STEP);
  localparam logic [PWM_W-1:0] FLOOR = PWM_W'(MIN_DUTY);

  bl_state_e        r_state;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;
  logic             r_period_start;

  logic             w_tick;
  logic             w_clear;
  logic             w_boundary;
  logic [PWM_W-1:0] w_target;
  logic [PWM_W-1:0] w_entry_duty;
  logic [PWM_W:0]   w_next_duty;

  assign w_target     = umax(I_bright_data, FLOOR);
  assign w_entry_duty = umin(STEP, w_target);
  // One extra bit so the ramp addition can never wrap past the target.
  assign w_next_duty  = {1'b0, r_duty} + {1'b0, STEP};
  assign w_clear      = (r_state == OFF) || !I_enable;
  assign w_boundary   = w_tick && (r_pwm_cnt == PWM_LAST);

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .i_clk  (I_clk),
    .i_reset(I_reset),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  // Controller: state, period counter, applied duty and the registered
  // outputs. Disable overrides everything including a coincident boundary.
  // O_pwm compares the current registers, so it lags the counter by a cycle.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state        <= OFF;
      r_pwm_cnt      <= '0;
      r_duty         <= '0;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= (r_state != OFF) && (r_pwm_cnt < r_duty);
      r_period_start <= 1'b0;
      if (!I_enable) begin
        r_state   <= OFF;
        r_pwm_cnt <= '0;
        r_duty    <= '0;
      end else begin
        case (r_state)
          OFF: begin
            // Entry behaves like a boundary: a fresh period starts now.
            r_state        <= (w_entry_duty == w_target) ? RUN : RAMP;
            r_pwm_cnt      <= '0;
            r_duty         <= w_entry_duty;
            r_period_start <= 1'b1;
          end
          RAMP, RUN: begin
            if (w_tick) begin
              r_pwm_cnt <= w_boundary ? '0 : r_pwm_cnt + 1'b1;
            end
            if (w_boundary) begin
              r_period_start <= 1'b1;
              if (r_state == RUN) begin
                r_duty <= w_target;
              end else if ((w_next_duty >= {1'b0, w_target}) ||
                           (w_target < r_duty)) begin
                // Target reached or dropped below the ramp: jump to it.
                r_duty  <= w_target;
                r_state <= RUN;
              end else begin
                r_duty <= w_next_duty[PWM_W-1:0];
              end
            end
          end
          default: begin
            r_state   <= OFF;
            r_pwm_cnt <= '0;
            r_duty    <= '0;
          end
        endcase
      end
    end
  end

  assign O_pwm          = r_pwm;
  assign O_period_start = r_period_start;
  assign O_duty         = r_duty;
  assign O_ramping      = (r_state == RAMP);

endmodule

// File: tb/tb_backlight_pwm.sv
// Directed testbench for backlight_pwm.
// Instance A (PRESCALE 1, RAMP_STEP 1000, MIN_DUTY 32) covers reset, soft
// start, mid-period changes, the floor, full duty and disable/re-enable.
// Instance B (PRESCALE 3, MIN_DUTY 0) runs in parallel and covers the
// prescaled period length and high time.
module tb_backlight_pwm;

  logic        clk;
  logic        aReset, aEnable;
  logic [11:0] aBright;
  logic        aPwm, aPeriodStart, aRamping;
  logic [11:0] aDuty;
  logic        bReset, bEnable;
  logic [11:0] bBright;
  logic        bPwm, bPeriodStart, bRamping;
  logic [11:0] bDuty;

  int checks   = 0;
  int failures = 0;

  backlight_pwm #(
    .PRESCALE (1),
    .RAMP_STEP(1000),
    .MIN_DUTY (32)
  ) dutA (
    .I_clk         (clk),
    .I_reset       (aReset),
    .I_enable      (aEnable),
    .I_bright_data (aBright),
    .O_pwm         (aPwm),
    .O_period_start(aPeriodStart),
    .O_duty        (aDuty),
    .O_ramping     (aRamping)
  );

  backlight_pwm #(
    .PRESCALE (3),
    .RAMP_STEP(64),
    .MIN_DUTY (0)
  ) dutB (
    .I_clk         (clk),
    .I_reset       (bReset),
    .I_enable      (bEnable),
    .I_bright_data (bBright),
    .O_pwm         (bPwm),
    .O_period_start(bPeriodStart),
    .O_duty        (bDuty),
    .O_ramping     (bRamping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #950000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic reset, input logic enable, input logic [11:0] bright);
    aReset  = reset;
    aEnable = enable;
    aBright = bright;
  endtask

  // Called just after a period-start sample. Counts O_pwm highs over the
  // following period; the sample at the next period start still belongs to
  // this period because O_pwm lags the counter by one cycle. Optionally
  // changes instance A's brightness when the counter reads changeAt.
  task automatic measurePeriod(input bit useB, input int changeAt, input logic [11:0] newBright,
                               output int highs, output int cycles);
    bit done;
    highs  = 0;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 13000) begin
      @(negedge clk);
      cycles++;
      if (!useB && cycles == changeAt) aBright = newBright;
      highs += useB ? int'(bPwm) : int'(aPwm);
      if (useB ? bPeriodStart : aPeriodStart) done = 1'b1;
    end
    if (!done) checkOutput(useB ? "B_period_timeout" : "A_period_timeout", 0, 1);
  endtask

  // Checks one period of instance A: high count, length, and the duty and
  // ramp flag loaded at the closing boundary.
  task automatic checkPeriodA(input string tag, input int changeAt, input logic [11:0] newBright,
                              input int expHighs, input int expNextDuty, input int expRamping);
    int highs, cycles;
    measurePeriod(1'b0, changeAt, newBright, highs, cycles);
    checkOutput({tag, "_highs"}, highs, expHighs);
    checkOutput({tag, "_len"}, cycles, 4095);
    checkOutput({tag, "_next_duty"}, aDuty, expNextDuty);
    checkOutput({tag, "_ramping"}, aRamping, expRamping);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 12'd2000);
    bReset  = 1'b1;
    bEnable = 1'b1;
    bBright = 12'd10;

    fork
      begin : streamA
        // Reset dominates enable for every cycle it is held.
        repeat (5) begin
          @(negedge clk);
          checkOutput("reset_pwm", aPwm, 0);
          checkOutput("reset_duty", aDuty, 0);
          checkOutput("reset_period_start", aPeriodStart, 0);
        end

        // Soft start towards 3000 in 1000 steps.
        applyStimulus(1'b0, 1'b1, 12'd3000);
        @(negedge clk);
        checkOutput("entry_period_start", aPeriodStart, 1);
        checkOutput("entry_duty", aDuty, 1000);
        checkOutput("entry_ramping", aRamping, 1);
        checkPeriodA("ramp1", -1, 12'd0, 1000, 2000, 1);
        checkPeriodA("ramp2", -1, 12'd0, 2000, 3000, 0);

        // New brightness mid-period only lands at the boundary.
        aBright = 12'd1000;
        checkPeriodA("run3000", -1, 12'd0, 3000, 1000, 0);
        checkPeriodA("mid_change", 200, 12'd500, 1000, 500, 0);
        checkPeriodA("run500", -1, 12'd0, 500, 500, 0);

        // Zero brightness is floored to MIN_DUTY.
        aBright = 12'd0;
        checkPeriodA("to_floor", -1, 12'd0, 500, 32, 0);
        checkPeriodA("floor", -1, 12'd0, 32, 32, 0);

        // Full brightness keeps O_pwm high across the whole period.
        aBright = 12'd4095;
        checkPeriodA("to_full", -1, 12'd0, 32, 4095, 0);
        checkPeriodA("full", -1, 12'd0, 4095, 4095, 0);
        aBright = 12'd3000;
        checkPeriodA("full_to_3000", -1, 12'd0, 4095, 3000, 0);

        // Disable at counter 100 with duty 3000.
        repeat (100) @(negedge clk);
        aEnable = 1'b0;
        @(negedge clk);
        checkOutput("disable_duty", aDuty, 0);
        checkOutput("disable_ramping", aRamping, 0);
        @(negedge clk);
        checkOutput("disable_pwm_low", aPwm, 0);
        repeat (3) @(negedge clk);
        checkOutput("off_pwm", aPwm, 0);

        // Re-enable restarts the ramp with an immediate period start.
        aEnable = 1'b1;
        @(negedge clk);
        checkOutput("reenable_period_start", aPeriodStart, 1);
        checkOutput("reenable_duty", aDuty, 1000);
        checkOutput("reenable_pwm_not_yet", aPwm, 0);
        @(negedge clk);
        checkOutput("reenable_pwm_high", aPwm, 1);
        checkOutput("reenable_period_start_pulse", aPeriodStart, 0);
      end

      begin : streamB
        int highs, cycles;
        repeat (3) @(negedge clk);
        bReset = 1'b0;
        @(negedge clk);
        checkOutput("B_entry_period_start", bPeriodStart, 1);
        checkOutput("B_entry_duty", bDuty, 10);
        checkOutput("B_entry_ramping", bRamping, 0);
        repeat (2) begin
          measurePeriod(1'b1, -1, 12'd0, highs, cycles);
          checkOutput("B_highs", highs, 30);
          checkOutput("B_period_len", cycles, 12285);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/backlight_pwm.md
# backlight_pwm

Single-channel MiniLED backlight PWM generator, directly downstream of the ambient-light driver. Consumes the smoothed 12-bit brightness word and produces a glitch-free PWM drive for the LED backlight. Duty changes take effect only at period boundaries. A soft-start ramp runs on enable, and a configurable minimum-duty floor is applied.

## Interface
- PRESCALE, 1, clocks per PWM tick; legal range is 1..65535.
- RAMP_STEP, 64, duty increment per period during soft-start; legal range is 1..4095.
- MIN_DUTY, 32, floor applied to the enabled target duty; legal range is 0..4095.

Ports:
- I_clk  in  1  system clock; one clock domain.
- I_reset  in  1  synchronous, active-high reset.
- I_enable  in  1  backlight enable, level-sensitive.
- I_bright_data  in  12  requested brightness, sampled every cycle with no handshake.
- O_pwm  out  1  PWM drive, registered.
- O_period_start  out  1  one-cycle pulse marking the start of a PWM period.
- O_duty  out  12  duty currently applied, equal to the internal duty register.
- O_ramping  out  1  high while in RAMP.

## Operation
- Target duty: target = max(I_bright_data, MIN_DUTY). It is evaluated combinationally each cycle.
- Counters:
  - presc_cnt counts 0..PRESCALE-1. tick is asserted when presc_cnt == PRESCALE-1.
  - pwm_cnt is 12 bits and counts 0..4094, advancing on tick. The period is 4095 ticks, so duty 4095 means 100% and duty 0 means 0%.
- Boundary: a boundary occurs when tick is asserted and pwm_cnt == 4094. On a boundary, pwm_cnt goes to 0, duty is updated per the current state, and O_period_start is asserted on the next cycle.
- States:
  - OFF: counters are held at 0, duty = 0, O_pwm = 0.
    - If I_enable = 1, go to RAMP.
    - On that entry cycle, the registers load presc_cnt = 0, pwm_cnt = 0, duty = min(RAMP_STEP, target), and O_period_start = 1.
    - If min(RAMP_STEP, target) == target, go directly to RUN instead.
  - RAMP: at each boundary, nd = duty + RAMP_STEP, computed 13 bits wide.
    - If nd >= target, or target < duty, then duty = target and go to RUN.
    - Otherwise duty = nd.
  - RUN: at each boundary, duty = target. There is no slew limit; upstream already smooths.
  - Any state with I_enable = 0 goes to OFF on the next cycle, with duty = 0 and counters cleared. The current period is not completed.
- O_pwm <= (state != OFF) && (pwm_cnt < duty). It is registered from the current register values.
- Arithmetic is unsigned throughout. Ramp additions use 13 bits and saturate against target, so they never wrap.
- Changes to I_bright_data mid-period do not affect O_pwm until the next boundary.

## Timing
- Reset values: state = OFF, presc_cnt = 0, pwm_cnt = 0, duty = 0, O_pwm = 0, O_period_start = 0, O_duty = 0, O_ramping = 0.
- Reset takes priority over I_enable. Reset mid-period returns every register to its reset value on the next edge.
- Period length is PRESCALE × 4095 clocks.
- O_pwm lags the counter by 1 cycle. In the first cycle of a period, O_pwm reflects the previous period's last compare. O_period_start is aligned with the cycle in which pwm_cnt reads 0.
- High time per period is exactly duty × PRESCALE clocks.
- I_enable rising edge to the first O_pwm high takes 2 cycles, provided the entry duty is > 0.
- I_enable falling edge to O_pwm low takes at most 2 cycles.
- Simultaneous boundary and I_enable falling: disable wins.
- PRESCALE = 1 means tick every cycle.

## Structure
- Shared package bl_pkg holds:
  - PWM_MAX = 4095 and PWM_W = 12.
  - State encoding: OFF = 2'b00, RAMP = 2'b01, RUN = 2'b10.
- One natural sub-module, pwm_tick_gen, is the prescaler. It is parameterised by PRESCALE, outputs tick, and has a synchronous clear used on OFF entry.
- Expected size is about 150–200 lines of RTL.

## Test plan
- Reset check: hold I_reset high for 5 cycles with I_enable = 1 and I_bright_data = 2000. Required: O_pwm = 0, O_duty = 0, O_period_start = 0 throughout.
- Soft-start: PRESCALE = 1, RAMP_STEP = 1000, target 3000.
  - Required O_duty sequence is 1000, 2000, then 3000 at successive boundaries.
  - O_ramping falls when 3000 loads.
  - O_pwm high count per period equals O_duty.
- Floor and extremes: I_bright_data = 0 with MIN_DUTY = 32 gives 32 high cycles per 4095. I_bright_data = 4095 gives O_pwm continuously high across periods.
- Mid-period change: in RUN with duty 1000, change I_bright_data to 500 at pwm_cnt = 200. The current period keeps 1000 high cycles and the next period has 500.
- Disable: drop I_enable at pwm_cnt = 100 with duty 3000. Required:
  - O_pwm is low within 2 cycles and O_duty = 0.
  - Re-enable produces O_period_start on the entry cycle and duty = min(RAMP_STEP, target).
- Prescale: PRESCALE = 3 and duty 10 give 30 high clocks per 12285-clock period. O_period_start spacing is 12285.
